// File: rtl/rv32i_pkg.sv
// Shared RV32I core types and sizes, plus the writeback request bundle used by the
// register-file writeback arbiter.
package rv32i_pkg;

    localparam int XLEN           = 32;
    localparam int REG_COUNT      = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int WB_STARVE_W    = 4;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [XLEN-1:0]           wdata;
    } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set at issue
// and cleared when the register file commits the matching writeback.
module wb_scoreboard
    import rv32i_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    output logic                      issue_ready,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    input  logic                      wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] wr_addr
);

    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;

    always_comb begin
        // A register being committed this cycle may be re-issued immediately.
        issue_ready = !busy_q[issue_rd] || (wr_en && (wr_addr == issue_rd));
        busy_d      = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        // Set is applied after clear so a same-index set wins.
        if (issue_valid && issue_ready && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy = busy_q[rs1_addr];
    assign rs2_busy = busy_q[rs2_addr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU and LSU writebacks:
// LSU has fixed priority, and a starvation counter forces an ALU grant.
module regfile_wb_arbiter
    import rv32i_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    output logic                      issue_ready,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
    input  logic [XLEN-1:0]           alu_wdata,
    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic [REG_ADDR_WIDTH-1:0] lsu_rd,
    input  logic [XLEN-1:0]           lsu_wdata,
    output logic                      rf_wr_en,
    output logic [REG_ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [XLEN-1:0]           rf_wdata
);

    localparam logic [WB_STARVE_W-1:0] LIMIT = WB_STARVE_W'(STARVE_LIMIT);

    wb_req_t                   alu_req;
    wb_req_t                   lsu_req;
    wb_req_t                   win;
    logic                      force_alu;
    logic                      alu_xfer;
    logic                      lsu_xfer;
    logic [WB_STARVE_W-1:0]    starve_q, starve_d;
    logic                      wr_en_q, wr_en_d;
    logic [REG_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]           wdata_q, wdata_d;

    assign alu_req = '{valid: alu_valid, rd: alu_rd, wdata: alu_wdata};
    assign lsu_req = '{valid: lsu_valid, rd: lsu_rd, wdata: lsu_wdata};

    always_comb begin
        force_alu = alu_req.valid && (starve_q == LIMIT);
        lsu_ready = !force_alu;
        alu_ready = force_alu || !lsu_req.valid;
        lsu_xfer  = lsu_req.valid && lsu_ready;
        alu_xfer  = alu_req.valid && alu_ready;

        win       = '0;
        if (lsu_xfer) begin
            win = lsu_req;
        end else if (alu_xfer) begin
            win = alu_req;
        end

        starve_d = starve_q;
        if (alu_xfer) begin
            starve_d = '0;
        end else if (alu_req.valid && (starve_q != LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end

        // x0 writebacks are consumed but never reach the register file.
        wr_en_d   = win.valid && (win.rd != '0);
        wr_addr_d = win.valid ? win.rd : wr_addr_q;
        wdata_d   = win.valid ? win.wdata : wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wdata_q   <= '0;
        end else begin
            starve_q  <= starve_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign rf_wr_en   = wr_en_q;
    assign rf_wr_addr = wr_addr_q;
    assign rf_wdata   = wdata_q;

    wb_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .wr_en       (wr_en_q),
        .wr_addr     (wr_addr_q)
    );

endmodule
